// File: rtl/multiply_divide_unit_pkg.sv
// Shared constants for the execute stage: ALU and MDU operation codes, MDU timing and FSM states.
// The madd/msub codes always exist; whether the MDU honours them depends on MDU_MADD_EN.
package multiply_divide_unit_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    localparam logic [3:0] MDU_MUL_CYCLES = 4'd5;
    localparam logic [3:0] MDU_DIV_CYCLES = 4'd10;

    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/multiply_divide_unit.sv
// HI/LO multiply-divide unit: result computed at start, staged, committed when busy falls.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulate into {hi,lo}.
module multiply_divide_unit
    import multiply_divide_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ctrl,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output mdu_state_e  o_dbg_state
);

    mdu_state_e  r_state;
    mdu_state_e  w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    logic        w_launch;
    logic        w_commit;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_stage_hi;
    logic [31:0] r_stage_lo;
    logic        r_stage_wr;

    logic        w_op_mul;
    logic        w_op_div;
    logic [31:0] w_stage_hi;
    logic [31:0] w_stage_lo;
    logic        w_stage_wr;

    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_div_ovf;
    logic [31:0]        w_divs_b;
    logic [31:0]        w_divu_b;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic [31:0]        w_quo_u;
    logic [31:0]        w_rem_u;

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'b0, A} * {32'b0, B};

    // Divide by 1 instead of 0 or at the signed overflow point; both cases come out right
    // (zero-divide is never committed, and MIN/1 is exactly the wrapped MIN/-1 quotient).
    assign w_div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign w_divs_b  = ((B == 32'd0) || w_div_ovf) ? 32'd1 : B;
    assign w_divu_b  = (B == 32'd0) ? 32'd1 : B;
    assign w_quo_s   = $signed(A) / $signed(w_divs_b);
    assign w_rem_s   = $signed(A) % $signed(w_divs_b);
    assign w_quo_u   = A / w_divu_b;
    assign w_rem_u   = A % w_divu_b;

    always_comb begin
        w_op_mul   = 1'b0;
        w_op_div   = 1'b0;
        w_stage_hi = 32'd0;
        w_stage_lo = 32'd0;
        w_stage_wr = 1'b0;
        case (ctrl)
            MDU_MULT: begin
                w_op_mul                 = 1'b1;
                w_stage_wr               = 1'b1;
                {w_stage_hi, w_stage_lo} = w_prod_s;
            end
            MDU_MULTU: begin
                w_op_mul                 = 1'b1;
                w_stage_wr               = 1'b1;
                {w_stage_hi, w_stage_lo} = w_prod_u;
            end
            MDU_DIV: begin
                w_op_div   = 1'b1;
                w_stage_wr = (B != 32'd0);
                w_stage_hi = w_rem_s;
                w_stage_lo = w_quo_s;
                if (w_div_ovf) begin
                    w_stage_hi = 32'd0;
                end
            end
            MDU_DIVU: begin
                w_op_div   = 1'b1;
                w_stage_wr = (B != 32'd0);
                w_stage_hi = w_rem_u;
                w_stage_lo = w_quo_u;
            end
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                w_op_mul                 = 1'b1;
                w_stage_wr               = 1'b1;
                {w_stage_hi, w_stage_lo} = {r_hi, r_lo} + w_prod_s;
            end
            MDU_MADDU: begin
                w_op_mul                 = 1'b1;
                w_stage_wr               = 1'b1;
                {w_stage_hi, w_stage_lo} = {r_hi, r_lo} + w_prod_u;
            end
            MDU_MSUB: begin
                w_op_mul                 = 1'b1;
                w_stage_wr               = 1'b1;
                {w_stage_hi, w_stage_lo} = {r_hi, r_lo} - w_prod_s;
            end
            MDU_MSUBU: begin
                w_op_mul                 = 1'b1;
                w_stage_wr               = 1'b1;
                {w_stage_hi, w_stage_lo} = {r_hi, r_lo} - w_prod_u;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_launch     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            MDU_IDLE: begin
                if (start && (w_op_mul || w_op_div)) begin
                    w_next_state = MDU_RUN;
                    w_next_cnt   = w_op_div ? MDU_DIV_CYCLES : MDU_MUL_CYCLES;
                    w_launch     = 1'b1;
                end
            end
            MDU_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = MDU_IDLE;
                    w_next_cnt   = 4'd0;
                    w_commit     = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = MDU_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MDU_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // mthi/mtlo only act in IDLE, so they can never collide with a commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_stage_hi <= 32'd0;
            r_stage_lo <= 32'd0;
            r_stage_wr <= 1'b0;
        end else begin
            if (w_launch) begin
                r_stage_hi <= w_stage_hi;
                r_stage_lo <= w_stage_lo;
                r_stage_wr <= w_stage_wr;
            end
            if (w_commit && r_stage_wr) begin
                r_hi <= r_stage_hi;
                r_lo <= r_stage_lo;
            end else if ((r_state == MDU_IDLE) && start && (ctrl == MDU_MTHI)) begin
                r_hi <= A;
            end else if ((r_state == MDU_IDLE) && start && (ctrl == MDU_MTLO)) begin
                r_lo <= A;
            end
        end
    end

    assign busy        = (r_state == MDU_RUN);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Bench for multiply_divide_unit: directed corner cases plus random ops against a 64-bit arithmetic model.
// Compile with MDU_MADD_EN defined to exercise the accumulate ops.
module tb_multiply_divide_unit;
    import multiply_divide_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ctrl;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    mdu_state_e  dbg_state;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_acc;

    multiply_divide_unit dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .ctrl       (ctrl),
        .start      (start),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo),
        .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural effect of one accepted op in terms of plain 64-bit arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] acc, output logic [63:0] res, output int lat);
        int              ia;
        int              ib;
        longint          la;
        longint          lb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        ia = a;  ib = b;
        la = ia; lb = ib;
        ua = a;  ub = b;
        res = acc;
        lat = 0;
        case (op)
            MDU_MULT:  begin res = la * lb; lat = 5; end
            MDU_MULTU: begin res = ua * ub; lat = 5; end
            MDU_DIV: begin
                lat = 10;
                if (b != 0) begin
                    q = la / lb;
                    r = la % lb;
                    res = {r[31:0], q[31:0]};
                end
            end
            MDU_DIVU: begin
                lat = 10;
                if (b != 0) begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
            end
            MDU_MTHI: res = {a, acc[31:0]};
            MDU_MTLO: res = {acc[63:32], a};
`ifdef MDU_MADD_EN
            MDU_MADD:  begin res = acc + la * lb; lat = 5; end
            MDU_MADDU: begin res = acc + ua * ub; lat = 5; end
            MDU_MSUB:  begin res = acc - la * lb; lat = 5; end
            MDU_MSUBU: begin res = acc - ua * ub; lat = 5; end
`endif
            default: ;
        endcase
    endfunction

    // Issue one op, check hi/lo hold while busy, busy length, and the committed result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] nxt;
        int          lat;
        int          n;
        model(op, a, b, m_acc, nxt, lat);
        exp_q.push_back(nxt);
        @(negedge clk);
        ctrl = op; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ctrl = MDU_NONE; A = $urandom; B = $urandom;
        n = 0;
        while (busy && n < 40) begin
            check({tag, "_hold"}, {hi, lo}, m_acc);
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(lat));
        check({tag, "_result"}, {hi, lo}, exp_q.pop_front());
        m_acc = nxt;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] corner[5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 40)) - 32'd20;
        return $urandom;
    endfunction

    initial begin
        logic [63:0] nxt;
        int          lat;
        int          n;
        logic [3:0]  op;

        reset = 1'b1; start = 1'b0; ctrl = MDU_NONE; A = '0; B = '0;
        m_acc = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_state", 64'(dbg_state), 64'(MDU_IDLE));

        run_op("mult_neg2x3", MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_neg2x3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu_neg2x3", MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
        check("multu_neg2x3_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_7_2", MDU_DIVU, 32'd7, 32'd2);
        check("divu_7_2_const", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("divu_ovf_pattern", MDU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

        run_op("mthi_1234", MDU_MTHI, 32'h0000_1234, 32'd0);
        check("mthi_1234_const", 64'(hi), 64'h1234);
        run_op("divu_by0", MDU_DIVU, 32'h5555_AAAA, 32'd0);
        run_op("div_by0", MDU_DIV, 32'hDEAD_BEEF, 32'd0);

        // mtlo during busy cycle 2 of a mult must be dropped.
        model(MDU_MULT, 32'h0001_0003, 32'h0002_0005, m_acc, nxt, lat);
        @(negedge clk);
        ctrl = MDU_MULT; A = 32'h0001_0003; B = 32'h0002_0005; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ctrl = MDU_NONE;
        n = 1;
        @(negedge clk);
        ctrl = MDU_MTLO; A = 32'hDEAD_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ctrl = MDU_NONE;
        n = 2;
        while (busy && n < 40) begin n++; @(negedge clk); end
        check("mtlo_in_busy_cycles", 64'(n), 64'(lat));
        check("mtlo_in_busy_result", {hi, lo}, nxt);
        m_acc = nxt;

        // Reset at busy cycle 4 of a div abandons it for good.
        @(negedge clk);
        ctrl = MDU_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ctrl = MDU_NONE;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_acc = '0;
        check("rst_run_busy", 64'(busy), 64'd0);
        check("rst_run_hilo", {hi, lo}, 64'd0);
        repeat (12) @(negedge clk);
        check("rst_run_no_commit", {hi, lo}, 64'd0);

        run_op("pre_rst_prio", MDU_MTLO, 32'h0BAD_F00D, 32'd0);
        @(negedge clk);
        reset = 1'b1; ctrl = MDU_MULT; A = 32'd3; B = 32'd5; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; ctrl = MDU_NONE;
        m_acc = '0;
        check("rst_prio_busy", 64'(busy), 64'd0);
        check("rst_prio_hilo", {hi, lo}, 64'd0);

        run_op("madd_prep_hi", MDU_MTHI, 32'd0, 32'd0);
        run_op("madd_prep_lo", MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
        run_op("maddu_1x1", MDU_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        check("maddu_1x1_const", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        check("maddu_1x1_const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif
        run_op("msub_m3x5", MDU_MSUB, 32'hFFFF_FFFD, 32'd5);
        run_op("msubu_big", MDU_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("madd_neg", MDU_MADD, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 10));
            run_op($sformatf("rand%0d_op%0d", i, op), op, rand_word(),
                   ($urandom_range(0, 7) == 0) ? 32'd0 : rand_word());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiply_divide_unit.md
MULTIPLY_DIVIDE_UNIT -- requirements
Module: multiply_divide_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 A  input  32  first operand (rs), the same value the execute-stage ALU receives.
REQ-005 B  input  32  second operand (rt), the same value the execute-stage ALU receives.
REQ-006 ctrl  input  4  operation code: mduNone, mduMult, mduMultu, mduDiv, mduDivu, mduMthi, mduMtlo, plus mduMadd, mduMaddu, mduMsub, mduMsubu when the macro is on.
REQ-007 start  input  1  qualifies ctrl for one cycle; the operation is ignored when start=0.
REQ-008 busy  output  1  high while a mult/div is in flight.
REQ-009 hi  output  32  architectural HI register.
REQ-010 lo  output  32  architectural LO register.

Function
REQ-011 mult/multu SHALL hold the 64-bit signed/unsigned product of A and B: {hi,lo} = A*B.
REQ-012 div/divu SHALL give a signed/unsigned quotient in lo and remainder in hi; the quotient truncates toward zero and the remainder takes the sign of A.
REQ-013 The result SHALL be computed in the start cycle and held in a private staging register; hi/lo SHALL not change until the last busy cycle is complete.
REQ-014 Latency: after start with mult* or madd*, busy SHALL be 1 for exactly 5 cycles; after div*, exactly 10 cycles; hi/lo SHALL update on the clock edge at which busy falls.
REQ-015 FSM states: IDLE and RUN.
  - IDLE to RUN on start with a mult/div/madd op; the down-counter loads 5 or 10.
  - RUN to IDLE when the counter reaches 1; staging is committed on that edge.
REQ-016 mthi/mtlo with start in IDLE SHALL write A into hi/lo on the next edge, with no busy.
REQ-017 Any start while busy=1 SHALL be ignored, including mthi/mtlo; the stall is the hazard unit's job.
REQ-018 div/divu with B=0 SHALL still run the full 10 busy cycles and SHALL leave hi/lo unchanged.
REQ-019 Signed div of 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0, with no trap.
REQ-020 busy SHALL be registered (a pure FSM output), never combinational from start.
REQ-021 hi/lo SHALL remain readable every cycle, showing the last committed values while busy.

Reset
REQ-022 Reset SHALL force the FSM to IDLE, busy=0, hi=0, lo=0, the counter to 0 and staging to 0.
REQ-023 Reset during RUN SHALL abandon the operation; no partial commit may occur.
REQ-024 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-025 Macro MDU_MADD_EN:
  - When defined, madd/maddu SHALL set {hi,lo} += A*B and msub/msubu SHALL set {hi,lo} -= A*B.
  - The accumulate uses the {hi,lo} value at start, takes 5 cycles and commits modulo 2^64.
REQ-026 When MDU_MADD_EN is undefined, madd/msub codes SHALL be treated as mduNone: no busy and no state change.

Structure
REQ-027 The mdu* operation codes SHALL be defined in the shared constants header alongside the alu* codes; no literals in RTL.
REQ-028 The block SHALL be a single module with no sub-module, using the behavioural * and / operators into the staging register.

Verification
REQ-029 mult A=0xFFFFFFFE B=3:
  - busy SHALL be high for 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu with the same operands SHALL give hi=0x2, lo=0xFFFFFFFA.
REQ-030 div A=-7 B=2:
  - busy SHALL be high for 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu A=7 B=2 SHALL give lo=3, hi=1.
REQ-031 mthi A=0x1234 then divu B=0:
  - hi SHALL be 0x1234 after 1 cycle.
  - After the 10 busy cycles, hi/lo SHALL be unchanged.
REQ-032 mult start, then mtlo start at cycle 2 of busy:
  - The mtlo SHALL be ignored.
  - lo SHALL end up equal to the product.
REQ-033 div start, then reset at busy cycle 4:
  - Next cycle: busy=0, hi=lo=0.
  - No later commit SHALL occur.
REQ-034 With MDU_MADD_EN defined, hi=0 and lo=0xFFFFFFFF, then maddu A=1 B=1:
  - Result SHALL be hi=1, lo=0.
  - Without the macro, busy SHALL stay 0 and hi/lo SHALL be unchanged.
